// File: rtl/rtc_pkg.sv
// Shared types, limits and BCD helpers for the rtc_alarm real-time clock.
package rtc_pkg;

  typedef logic [7:0] bcd8_t;

  typedef enum logic {RUN, CHECK} state_t;

  localparam bcd8_t SEC_MAX = 8'h59;
  localparam bcd8_t MIN_MAX = 8'h59;
  localparam bcd8_t HR_MAX  = 8'h23;

  // Both digits decimal and the packed value no larger than max (BCD orders like hex).
  function automatic logic bcd_valid(bcd8_t v, bcd8_t max);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
  endfunction

  function automatic bcd8_t bcd_inc(bcd8_t v, bcd8_t max);
    if (v == max) return '0;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

endpackage

// File: rtl/rtc_alarm_bcd_wrap_cnt.sv
// Two-digit BCD counter wrapping at MAX; load has priority over increment.
module bcd_wrap_cnt
  import rtc_pkg::*;
#(
  parameter bcd8_t MAX = 8'h59
) (
  input  logic  clk50M,
  input  logic  rst,
  input  logic  inc,
  input  logic  load,
  input  bcd8_t load_val,
  output bcd8_t q,
  output logic  carry_out
);

  assign carry_out = inc & (q == MAX);

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk50M) begin
    if (rst)       q <= '0;
    else if (load) q <= load_val;
    else if (inc)  q <= bcd_inc(q, MAX);
  end

endmodule

// File: rtl/rtc_alarm.sv
// 24 h BCD real-time clock with validated time-set handshake and optional
// latched alarm (present when macro RTC_ALARM_EN is defined).
module rtc_alarm
  import rtc_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int ALARM_RING_S = 60
) (
  input  logic  clk50M,
  input  logic  rst,
  input  logic  clk1hz,
  input  logic  set_valid,
  output logic  set_ready,
  input  bcd8_t set_hh,
  input  bcd8_t set_mm,
  input  bcd8_t set_ss,
  output logic  set_err,
  input  logic  alm_we,
  input  bcd8_t alm_hh,
  input  bcd8_t alm_mm,
  input  logic  alm_en,
  input  logic  alm_ack,
  output bcd8_t hh,
  output bcd8_t mm,
  output bcd8_t ss,
  output logic  sec_tick,
  output logic  alarm
);

  // Flops preset to 1 so a clk1hz already high at reset release yields no tick.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   tick;

  always_ff @(posedge clk50M) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], clk1hz};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick = sync_q[SYNC_STAGES-1] & ~prev_q;

  state_t state;
  bcd8_t  cap_hh, cap_mm, cap_ss;
  logic   pending;
  logic   accept, cap_ok;
  logic   do_inc, do_load;
  logic   carry_ss, carry_mm, carry_hh;

  assign accept = (state == RUN) & set_valid & set_ready;
  assign cap_ok = bcd_valid(cap_hh, HR_MAX) & bcd_valid(cap_mm, MIN_MAX) &
                  bcd_valid(cap_ss, SEC_MAX);

  // NOTE: defaults first so no path through the block can infer a latch.
  always_comb begin
    do_inc  = 1'b0;
    do_load = 1'b0;
    case (state)
      RUN:   do_inc = tick & ~accept;
      CHECK: begin
        if (cap_ok) do_load = 1'b1;
        else        do_inc  = tick | pending;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      state     <= RUN;
      set_ready <= 1'b1;
      set_err   <= 1'b0;
      sec_tick  <= 1'b0;
      pending   <= 1'b0;
    end else begin
      sec_tick <= do_inc;
      set_err  <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            state     <= CHECK;
            set_ready <= 1'b0;
            pending   <= tick;
          end
        end
        CHECK: begin
          set_err   <= ~cap_ok;
          state     <= RUN;
          set_ready <= 1'b1;
          pending   <= 1'b0;
        end
        default: state <= RUN;
      endcase
    end
  end

  // NOTE: capture registers are pure datapath, only read in CHECK, so no reset.
  always_ff @(posedge clk50M) begin
    if (accept) begin
      cap_hh <= set_hh;
      cap_mm <= set_mm;
      cap_ss <= set_ss;
    end
  end

  bcd_wrap_cnt #(.MAX(SEC_MAX)) u_ss (
    .clk50M(clk50M), .rst(rst), .inc(do_inc), .load(do_load),
    .load_val(cap_ss), .q(ss), .carry_out(carry_ss)
  );

  bcd_wrap_cnt #(.MAX(MIN_MAX)) u_mm (
    .clk50M(clk50M), .rst(rst), .inc(carry_ss), .load(do_load),
    .load_val(cap_mm), .q(mm), .carry_out(carry_mm)
  );

  bcd_wrap_cnt #(.MAX(HR_MAX)) u_hh (
    .clk50M(clk50M), .rst(rst), .inc(carry_mm), .load(do_load),
    .load_val(cap_hh), .q(hh), .carry_out(carry_hh)
  );

`ifdef RTC_ALARM_EN
  localparam logic [7:0] RING_LAST = 8'(ALARM_RING_S - 1);

  bcd8_t      alm_hh_q, alm_mm_q;
  logic       alm_en_q;
  logic [7:0] ring_cnt;
  logic       alm_wr_ok, fire;
  bcd8_t      next_mm, next_hh;
  logic       unused_carry;

  assign unused_carry = carry_hh;
  assign alm_wr_ok    = alm_we & bcd_valid(alm_hh, HR_MAX) & bcd_valid(alm_mm, MIN_MAX);

  // Fire on the time the current tick is about to produce, so alarm and sec_tick align.
  assign next_mm = bcd_inc(mm, MIN_MAX);
  assign next_hh = (mm == MIN_MAX) ? bcd_inc(hh, HR_MAX) : hh;
  assign fire    = do_inc & alm_en_q & (ss == SEC_MAX) &
                   (next_mm == alm_mm_q) & (next_hh == alm_hh_q);

  always_ff @(posedge clk50M) begin
    if (rst) begin
      alm_hh_q <= '0;
      alm_mm_q <= '0;
      alm_en_q <= 1'b0;
      alarm    <= 1'b0;
      ring_cnt <= '0;
    end else begin
      if (alm_wr_ok) begin
        alm_hh_q <= alm_hh;
        alm_mm_q <= alm_mm;
        alm_en_q <= alm_en;
      end
      if (fire) begin
        alarm    <= 1'b1;
        ring_cnt <= '0;
      end else if (alarm) begin
        if (alm_ack || (alm_wr_ok && !alm_en)) begin
          alarm <= 1'b0;
        end else if (do_inc) begin
          if (ring_cnt == RING_LAST) alarm <= 1'b0;
          else                       ring_cnt <= ring_cnt + 8'd1;
        end
      end
    end
  end
`else
  logic unused_alm;
  assign unused_alm = ^{alm_we, alm_hh, alm_mm, alm_en, alm_ack, carry_hh,
                        8'(ALARM_RING_S)};
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_alarm.sv
// Scoreboard bench for rtc_alarm; alarm scenarios follow the RTC_ALARM_EN build.
module tb_rtc_alarm;

  logic       clk50M = 1'b0;
  logic       rst = 1'b1;
  logic       clk1hz = 1'b1;
  logic       set_valid = 1'b0;
  logic       set_ready;
  logic [7:0] set_hh = '0, set_mm = '0, set_ss = '0;
  logic       set_err;
  logic       alm_we = 1'b0;
  logic [7:0] alm_hh = '0, alm_mm = '0;
  logic       alm_en = 1'b0;
  logic       alm_ack = 1'b0;
  logic [7:0] hh, mm, ss;
  logic       sec_tick, alarm;

  rtc_alarm dut (
    .clk50M(clk50M), .rst(rst), .clk1hz(clk1hz),
    .set_valid(set_valid), .set_ready(set_ready),
    .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss), .set_err(set_err),
    .alm_we(alm_we), .alm_hh(alm_hh), .alm_mm(alm_mm), .alm_en(alm_en),
    .alm_ack(alm_ack), .hh(hh), .mm(mm), .ss(ss),
    .sec_tick(sec_tick), .alarm(alarm)
  );

  always #10 clk50M = ~clk50M;

  typedef struct packed {
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       alarm;
  } exp_t;

  exp_t sb[$];
  int   t_sec = 0;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [7:0] enc(int v);
    logic [3:0] t, o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic exp_t make_exp(logic a);
    exp_t e;
    e.hh    = enc(t_sec / 3600);
    e.mm    = enc((t_sec / 60) % 60);
    e.ss    = enc(t_sec % 60);
    e.alarm = a;
    return e;
  endfunction

  task automatic push_next(input logic a);
    t_sec = (t_sec + 1) % 86400;
    sb.push_back(make_exp(a));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk50M);
  endtask

  // One clk1hz period: counts sec_tick pulses and snapshots outputs at the first.
  task automatic edge_wait(output int pulses, output exp_t snap);
    pulses = 0;
    snap   = 'x;
    clk1hz = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 8) clk1hz = 1'b0;
      @(negedge clk50M);
      if (sec_tick === 1'b1) begin
        if (pulses == 0) snap = '{hh, mm, ss, alarm};
        pulses++;
      end
    end
  endtask

  task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                        output int err_pulses, output logic ready_mid);
    set_hh = h; set_mm = m; set_ss = s;
    set_valid = 1'b1;
    @(negedge clk50M);
    ready_mid = set_ready;
    set_valid = 1'b0;
    err_pulses = 0;
    repeat (3) begin
      @(negedge clk50M);
      if (set_err === 1'b1) err_pulses++;
    end
  endtask

  task automatic alm_write(input logic [7:0] h, input logic [7:0] m, input logic en);
    alm_hh = h; alm_mm = m; alm_en = en;
    alm_we = 1'b1;
    @(negedge clk50M);
    alm_we = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    clk1hz = 1'b1;
    cyc(4);
    rst = 1'b0;
    @(negedge clk50M);
    checks++;
    if ({hh, mm, ss} !== 24'h000000 || set_ready !== 1'b1 || set_err !== 1'b0 ||
        sec_tick !== 1'b0 || alarm !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: time=%h:%h:%h ready=%b err=%b tick=%b alarm=%b, expected 00:00:00 1 0 0 0",
               hh, mm, ss, set_ready, set_err, sec_tick, alarm);
    end
    n = 0;
    repeat (10) begin
      @(negedge clk50M);
      if (sec_tick === 1'b1) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL high_at_reset: %0d sec_tick pulses, expected 0", n);
    end
    clk1hz = 1'b0;
    cyc(4);
    t_sec = 0;
  endtask

  task automatic test_count();
    int   pulses;
    exp_t snap, e;
    for (int k = 0; k < 3; k++) begin
      push_next(1'b0);
      edge_wait(pulses, snap);
      e = sb.pop_front();
      checks++;
      if (pulses != 1 || snap !== e) begin
        errors++;
        $display("FAIL count[%0d]: pulses=%0d got %h:%h:%h alarm=%b, expected 1 pulse %h:%h:%h alarm=%b",
                 k, pulses, snap.hh, snap.mm, snap.ss, snap.alarm, e.hh, e.mm, e.ss, e.alarm);
      end
    end
  endtask

  task automatic test_wrap();
    int   pulses, errp;
    logic rdy;
    exp_t snap, e;
    do_set(8'h23, 8'h59, 8'h58, errp, rdy);
    t_sec = 86398;
    checks++;
    if (errp != 0 || rdy !== 1'b0 || {hh, mm, ss} !== 24'h235958) begin
      errors++;
      $display("FAIL set_valid: err_pulses=%0d ready_mid=%b time=%h:%h:%h, expected 0 0 23:59:58",
               errp, rdy, hh, mm, ss);
    end
    for (int k = 0; k < 2; k++) begin
      push_next(1'b0);
      edge_wait(pulses, snap);
      e = sb.pop_front();
      checks++;
      if (pulses != 1 || snap !== e) begin
        errors++;
        $display("FAIL wrap[%0d]: pulses=%0d got %h:%h:%h alarm=%b, expected 1 pulse %h:%h:%h alarm=%b",
                 k, pulses, snap.hh, snap.mm, snap.ss, snap.alarm, e.hh, e.mm, e.ss, e.alarm);
      end
    end
  endtask

  task automatic test_bad_set();
    int         errp;
    logic       rdy;
    logic [23:0] bad [3];
    bad = '{24'h125A00, 24'h240000, 24'h123460};
    do_set(8'h12, 8'h34, 8'h56, errp, rdy);
    t_sec = 12 * 3600 + 34 * 60 + 56;
    for (int i = 0; i < 3; i++) begin
      do_set(bad[i][23:16], bad[i][15:8], bad[i][7:0], errp, rdy);
      checks++;
      if (errp != 1 || {hh, mm, ss} !== 24'h123456) begin
        errors++;
        $display("FAIL bad_set[%h]: err_pulses=%0d time=%h:%h:%h, expected 1 pulse 12:34:56",
                 bad[i], errp, hh, mm, ss);
      end
    end
  endtask

  task automatic test_alarm_fire();
    int   pulses, errp;
    logic rdy;
    exp_t snap, e;
    alm_write(8'h07, 8'h30, 1'b1);
`ifdef RTC_ALARM_EN
    do_set(8'h07, 8'h30, 8'h00, errp, rdy);
    cyc(2);
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL alarm_via_set: alarm=%b, expected 0", alarm);
    end
`endif
    do_set(8'h07, 8'h29, 8'h59, errp, rdy);
    t_sec = 7 * 3600 + 29 * 60 + 59;
`ifdef RTC_ALARM_EN
    push_next(1'b1);
`else
    push_next(1'b0);
`endif
    edge_wait(pulses, snap);
    e = sb.pop_front();
    checks++;
    if (pulses != 1 || snap !== e) begin
      errors++;
      $display("FAIL alarm_fire: pulses=%0d got %h:%h:%h alarm=%b, expected 1 pulse %h:%h:%h alarm=%b",
               pulses, snap.hh, snap.mm, snap.ss, snap.alarm, e.hh, e.mm, e.ss, e.alarm);
    end
`ifdef RTC_ALARM_EN
    alm_write(8'h24, 8'h00, 1'b0);
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL alarm_bad_write: alarm=%b, expected 1", alarm);
    end
    alm_ack = 1'b1;
    @(negedge clk50M);
    alm_ack = 1'b0;
    checks++;
    if (alarm !== 1'b0) begin
      errors++;
      $display("FAIL alarm_ack: alarm=%b, expected 0", alarm);
    end
`endif
  endtask

  task automatic test_alarm_timeout();
`ifdef RTC_ALARM_EN
    int   pulses, errp;
    logic rdy;
    exp_t snap, e;
    do_set(8'h07, 8'h29, 8'h59, errp, rdy);
    t_sec = 7 * 3600 + 29 * 60 + 59;
    for (int k = 0; k <= 60; k++) begin
      push_next(k < 60);
      edge_wait(pulses, snap);
      e = sb.pop_front();
      if (k == 0 || k >= 59) begin
        checks++;
        if (pulses != 1 || snap !== e) begin
          errors++;
          $display("FAIL ring[%0d]: pulses=%0d got %h:%h:%h alarm=%b, expected 1 pulse %h:%h:%h alarm=%b",
                   k, pulses, snap.hh, snap.mm, snap.ss, snap.alarm, e.hh, e.mm, e.ss, e.alarm);
        end
      end
    end
    do_set(8'h07, 8'h29, 8'h59, errp, rdy);
    clk1hz = 1'b1;
    cyc(2);
    alm_ack = 1'b1;
    @(negedge clk50M);
    alm_ack = 1'b0;
    checks++;
    if (sec_tick !== 1'b1 || alarm !== 1'b1 || {hh, mm, ss} !== 24'h073000) begin
      errors++;
      $display("FAIL ack_with_fire: tick=%b alarm=%b time=%h:%h:%h, expected 1 1 07:30:00",
               sec_tick, alarm, hh, mm, ss);
    end
    @(negedge clk50M);
    checks++;
    if (alarm !== 1'b1) begin
      errors++;
      $display("FAIL ack_with_fire_hold: alarm=%b, expected 1", alarm);
    end
    clk1hz = 1'b0;
    cyc(4);
    alm_ack = 1'b1;
    @(negedge clk50M);
    alm_ack = 1'b0;
`endif
  endtask

  task automatic collide(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                         output int extra_ticks);
    clk1hz = 1'b1;
    cyc(2);
    set_hh = h; set_mm = m; set_ss = s;
    set_valid = 1'b1;
    @(negedge clk50M);
    set_valid = 1'b0;
    @(negedge clk50M);
    extra_ticks = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) clk1hz = 1'b0;
      @(negedge clk50M);
      if (sec_tick === 1'b1) extra_ticks++;
    end
  endtask

  task automatic test_set_tick_collision();
    int   errp, extra;
    logic rdy;
    logic [23:0] t_at;
    logic        tk_at, er_at;
    do_set(8'h09, 8'h15, 8'h20, errp, rdy);
    fork
      collide(8'h10, 8'h00, 8'h00, extra);
      begin
        cyc(4);
        t_at = {hh, mm, ss}; tk_at = sec_tick; er_at = set_err;
      end
    join
    checks++;
    if (t_at !== 24'h100000 || tk_at !== 1'b0 || er_at !== 1'b0 || extra != 0) begin
      errors++;
      $display("FAIL collide_valid: time=%h tick=%b err=%b later_ticks=%0d, expected 100000 0 0 0",
               t_at, tk_at, er_at, extra);
    end
    do_set(8'h10, 8'h00, 8'h00, errp, rdy);
    fork
      collide(8'h10, 8'h0A, 8'h00, extra);
      begin
        cyc(4);
        t_at = {hh, mm, ss}; tk_at = sec_tick; er_at = set_err;
      end
    join
    checks++;
    if (t_at !== 24'h100001 || tk_at !== 1'b1 || er_at !== 1'b1 || extra != 0) begin
      errors++;
      $display("FAIL collide_invalid: time=%h tick=%b err=%b later_ticks=%0d, expected 100001 1 1 0",
               t_at, tk_at, er_at, extra);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_bad_set();
    test_alarm_fire();
    test_alarm_timeout();
    test_set_tick_collision();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
